// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and buffers {pc, instr}
// toward decode. Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module fetch_stage #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  ready_i,
    output logic                  misaligned_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IncBytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] PcInc = ADDR_WIDTH'(IncBytes);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(IncBytes - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic {StRun, StHalt} state_e;
    state_e state_q, state_d;
    logic   target_misaligned;

    assign target_misaligned = |(redirect_pc_i & AlignMask);
    assign redirect_target   = redirect_pc_i;

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = target_misaligned ? StHalt : StRun;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted       = (state_q == StHalt);
    assign misaligned_o = halted;
`else
    // Without the trap, misaligned targets are silently rounded down to a word boundary.
    assign redirect_target = redirect_pc_i & ~AlignMask;
    assign halted          = 1'b0;
    assign misaligned_o    = 1'b0;
`endif

    assign valid_o     = (count_q != '0);
    assign instr_o     = instr_mem_q[rd_ptr_q];
    assign pc_o        = pc_mem_q[rd_ptr_q];
    assign imem_addr_o = pc_q;

    assign pop  = valid_o & ready_i;
    assign push = ~redirect_i & ~halted & ((count_q < FullCnt) | pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            // A same-cycle pop is dropped with the flush; decode squashes it.
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + PcInc;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, drives the combinational read address of the instruction memory, and captures the returned word together with its PC into a small FIFO that feeds decode over a valid/ready handshake. It sits directly upstream of the instruction memory and between it and decode. Control-flow redirects from execute flush the FIFO and restart fetch at the new target.

## Interface
- `ADDR_WIDTH`, 32: PC / memory address width.
- `DATA_WIDTH`, 32: instruction width; the PC increment is `DATA_WIDTH/8`.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `FIFO_DEPTH`, 2: fetch buffer entries. Must be a power of two, ≥2.

- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `imem_addr_o` output ADDR_WIDTH: read address to instruction memory. Equals the PC register.
- `imem_data_i` input DATA_WIDTH: instruction word at `imem_addr_o`. Combinational, valid in the same cycle.
- `redirect_i` input 1: branch/jump taken; flush and restart fetch.
- `redirect_pc_i` input ADDR_WIDTH: redirect target.
- `valid_o` output 1: FIFO head holds a valid instruction.
- `instr_o` output DATA_WIDTH: head instruction.
- `pc_o` output ADDR_WIDTH: PC of head instruction.
- `ready_i` input 1: decode accepts the head this cycle.
- `misaligned_o` output 1: misaligned redirect target trapped. Tied 0 unless `FETCH_MISALIGN_TRAP_EN` is defined.

## Operation
- State: `pc_q`; FIFO storage of {pc, instr}; read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally; `count` of `$clog2(FIFO_DEPTH+1)` bits.
- `pop = valid_o & ready_i`. `push = !redirect_i & !halted & (count < FIFO_DEPTH | pop)`.
- On push: write {`pc_q`, `imem_data_i`} at the write pointer, then `pc_q <= pc_q + DATA_WIDTH/8`, with modulo 2^ADDR_WIDTH wrap. PC 0xFFFF_FFFC wraps to 0.
- On pop: advance the read pointer.
- `count` is incremented or decremented by push/pop. A simultaneous push and pop, including when full, leaves `count` unchanged.
- `valid_o = (count != 0)`. `instr_o` and `pc_o` are read from the head entry. While `valid_o=0`, their values are don't-care.
- On redirect (highest priority):
  - Pointers and `count` are cleared.
  - `pc_q <= redirect_pc_i`.
  - No push occurs that cycle.
  - A pop in the same cycle is treated as consumed; decode is responsible for squashing it.
- Back-to-back redirects: each one reloads the PC. Only the last one takes effect.
- States: RUN (normal) and HALT (only with the macro).
  - RUN → HALT on a redirect with a misaligned target.
  - HALT → RUN on the next redirect with an aligned target.
  - `halted` is 1 in HALT.
- Reset (asynchronous, at any time including mid-stream):
  - `pc_q = RESET_PC`, FIFO empty, state RUN.
  - Outputs: `valid_o=0`, `misaligned_o=0`, `imem_addr_o=RESET_PC`.

## Timing
- First instruction: `valid_o=1` after the first rising edge following reset deassertion, with `pc_o=RESET_PC`.
- Fetch-to-decode latency: 1 cycle. Sustained throughput: 1 instruction/cycle while `ready_i=1`.
- Redirect sampled at edge N:
  - `imem_addr_o = target` after edge N.
  - `valid_o=0` for the cycle following edge N.
  - Target instruction is valid after edge N+1. Redirect penalty: 1 bubble.
- With `ready_i=0`, the FIFO fills in FIFO_DEPTH cycles. The PC then holds, and `imem_addr_o` stays stable.
- Head entry and `valid_o` remain stable while `ready_i=0`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect whose target is not a multiple of `DATA_WIDTH/8` enters HALT.
  - `pc_q` is loaded with the raw target. `misaligned_o=1` from the next edge until the next aligned redirect or reset.
  - No pushes occur while halted. The FIFO is already flushed, so `valid_o=0`.
- Not defined:
  - The low `$clog2(DATA_WIDTH/8)` bits of `redirect_pc_i` are forced to 0.
  - No HALT state exists, and `misaligned_o` is tied to 0.

## Test plan
- Reset with `RESET_PC=0x100`, `ready_i=1`, memory preloaded → `pc_o` sequence 0x100, 0x104, 0x108, …, one per cycle, with `instr_o` matching memory. `valid_o=0` during reset.
- Hold `ready_i=0` for 5 cycles, then release → `count` saturates at 2 after 2 cycles and `imem_addr_o` holds at 0x108. On release, 0x100, 0x104, 0x108 are delivered in order with no loss or duplication.
- Redirect to 0x200 while the FIFO is full and `ready_i=1` → next cycle `valid_o=0`. The following cycle `pc_o=0x200`, then 0x204. No stale entries appear.
- Start with PC at 0xFFFF_FFF8, run 3 fetches → `pc_o` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Redirect to 0x202:
  - With the macro: `misaligned_o=1`, `valid_o` stays 0. A subsequent redirect to 0x300 clears `misaligned_o` and delivers 0x300.
  - Without the macro: delivers `pc_o=0x200`.
- Assert `rst_i` asynchronously mid-stream with a full FIFO → `valid_o` drops immediately without waiting for an edge. After release, fetch restarts at `RESET_PC`.
